spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Downstream readout stage for `spiking_network`. It samples the output spike lines `n7`/`n8` over a fixed window of clock cycles and counts the spikes on each line. At the end of the window it reports both counts and a winner classification, flagged by a one-cycle `valid` pulse. This turns the network's spike trains into a decision word for the rest of the chip.

## Interface
- `WINDOW`, 40, number of sampled cycles per decode window (≥2).
- `CNT_W`, 6, spike counter width; counters saturate at 2^CNT_W−1.
- `IDX_W`, `$clog2(WINDOW+1)`, cycle-index width (first-spike outputs only).
- `clk`  input  1  system clock; all sampling on rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `start`  input  1  request a new decode window; sampled on a rising edge.
- `n7`  input  1  output spike line 0 from `spiking_network`.
- `n8`  input  1  output spike line 1 from `spiking_network`.
- `busy`  output  1  high whenever the state is not IDLE.
- `valid`  output  1  one-cycle pulse; results are valid in that cycle.
- `count7`  output  CNT_W  spike count for `n7` in the last window.
- `count8`  output  CNT_W  spike count for `n8` in the last window.
- `winner`  output  2  00 = none, 01 = `n7`, 10 = `n8`, 11 = tie.
- `first7`, `first8`  output  IDX_W  index of the first spike on each line. Present only with `DECODER_TTFS_EN`.

## Operation
- FSM has three states: IDLE, COUNT, REPORT.
- IDLE, `start`=1: go to COUNT. Clear both internal accumulators and the cycle index. Load the first-spike trackers with the sentinel 2^IDX_W−1.
- COUNT: on each edge, sample `n7`/`n8`.
  - A line that is high increments its accumulator, saturating at 2^CNT_W−1. No wrap.
  - The cycle index runs 0..WINDOW−1.
  - On the edge that samples index WINDOW−1, go to REPORT.
- REPORT lasts exactly one cycle.
  - Registered outputs `count7`/`count8`/`winner` update at the transition into REPORT.
  - `valid`=1 during REPORT.
  - Next state: COUNT if `start`=1 in the REPORT cycle (back-to-back windows, accumulators cleared as from IDLE); otherwise IDLE.
- Winner rule:
  - Both counts 0: 00.
  - Otherwise the larger count wins: 01 or 10.
  - Equal nonzero counts: 11.
  - Comparison uses the saturated values.
- `start` is ignored in COUNT, with no effect and no queuing.
- Result outputs hold their values until the next REPORT. They do not change during a following COUNT.
- `n7`/`n8` are the registered outputs of the network and are sampled directly, with no synchronizer.

## Timing
- `start` sampled high at edge k gives:
  - samples at edges k+1 … k+WINDOW;
  - `valid` high for the cycle after edge k+WINDOW;
  - `busy` high from edge k to edge k+WINDOW+1, or longer if restarted in REPORT.
- Latency from the last sample to `valid` is 0 extra cycles: results are visible in the cycle right after the final sampling edge.
- Reset values:
  - state IDLE, `busy`=0, `valid`=0;
  - `count7`=`count8`=0, `winner`=00;
  - `first7`=`first8`=0;
  - all accumulators and the index 0.
- `rst` asserted mid-window aborts immediately and asynchronously. No `valid` pulse is issued for the aborted window.

## Configuration
- `DECODER_TTFS_EN` defined:
  - Adds time-to-first-spike tracking. Each tracker latches the cycle index of the first sampled high on its line. If the line never spikes, the tracker stays at the sentinel 2^IDX_W−1.
  - `first7`/`first8` are registered at the transition into REPORT, together with the counts.
  - Tie break: equal nonzero counts resolve to the line with the smaller first-spike index. Equal first-spike indices give 11.
- `DECODER_TTFS_EN` undefined:
  - Ports `first7`/`first8` and their logic are absent.
  - Ties always report 11.

## Test plan
- Reset mid-window: start, `n7`=1 for 10 cycles, assert `rst` → `busy`=0, `count7`=0, `winner`=00, no `valid` pulse.
- Rate win: `n7` high 10 cycles, `n8` high 5 cycles within the window → one `valid` pulse at cycle k+41, `count7`=10, `count8`=5, `winner`=01.
- Silence: no spikes on either line → `count7`=`count8`=0, `winner`=00, `valid` still pulses once.
- Saturation: `CNT_W`=5, `n7` constantly high for all 40 cycles → `count7`=31, `winner`=01.
- Tie: 8 spikes on each line; first `n8` spike at index 2, first `n7` spike at index 5.
  - With the macro: `winner`=10, `first8`=2, `first7`=5.
  - Without the macro: `winner`=11.
- Back-to-back: `start` held high continuously → a `valid` pulse every 41 cycles, `busy` never drops, `start` pulses during COUNT are ignored.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-rate readout: counts n7/n8 spikes over a WINDOW-cycle decode window and reports counts plus a winner.
// Optional time-to-first-spike tracking and tie break is enabled by defining DECODER_TTFS_EN.
module spike_rate_decoder #(
   parameter int WINDOW = 40,
   parameter int CNT_W  = 6,
   parameter int IDX_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             n7,
   input  logic             n8,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] count7,
   output logic [CNT_W-1:0] count8,
   output logic [1:0]       winner
`ifdef DECODER_TTFS_EN
   ,
   output logic [IDX_W-1:0] first7,
   output logic [IDX_W-1:0] first8
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);
   localparam logic [1:0]       W_NONE   = 2'b00;
   localparam logic [1:0]       W_N7     = 2'b01;
   localparam logic [1:0]       W_N8     = 2'b10;
   localparam logic [1:0]       W_TIE    = 2'b11;
`ifdef DECODER_TTFS_EN
   // Never a legal cycle index, so it doubles as "no spike seen yet".
   localparam logic [IDX_W-1:0] IDX_NONE = '1;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] acc7_q, acc7_d, acc8_q, acc8_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] count7_q, count7_d, count8_q, count8_d;
   logic [1:0]       winner_q, winner_d;
`ifdef DECODER_TTFS_EN
   logic [IDX_W-1:0] trk7_q, trk7_d, trk8_q, trk8_d;
   logic [IDX_W-1:0] first7_q, first7_d, first8_q, first8_d;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
      if (hit && (c != CNT_MAX)) return c + CNT_W'(1);
      return c;
   endfunction

`ifdef DECODER_TTFS_EN
   function automatic logic [1:0] pick_winner(input logic [CNT_W-1:0] c7, input logic [CNT_W-1:0] c8,
                                              input logic [IDX_W-1:0] f7, input logic [IDX_W-1:0] f8);
      if ((c7 == '0) && (c8 == '0)) return W_NONE;
      if (c7 > c8) return W_N7;
      if (c8 > c7) return W_N8;
      if (f7 < f8) return W_N7;
      if (f8 < f7) return W_N8;
      return W_TIE;
   endfunction
`else
   function automatic logic [1:0] pick_winner(input logic [CNT_W-1:0] c7, input logic [CNT_W-1:0] c8);
      if ((c7 == '0) && (c8 == '0)) return W_NONE;
      if (c7 > c8) return W_N7;
      if (c8 > c7) return W_N8;
      return W_TIE;
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_COUNT;
         S_COUNT:  if (idx_q == IDX_LAST) state_d = S_REPORT;
         S_REPORT: state_d = start ? S_COUNT : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != S_IDLE);
      valid = (state_q == S_REPORT);
   end

   always_comb begin
      acc7_d   = acc7_q;
      acc8_d   = acc8_q;
      idx_d    = idx_q;
      count7_d = count7_q;
      count8_d = count8_q;
      winner_d = winner_q;
`ifdef DECODER_TTFS_EN
      trk7_d   = trk7_q;
      trk8_d   = trk8_q;
      first7_d = first7_q;
      first8_d = first8_q;
`endif
      if (state_q == S_COUNT) begin
         acc7_d = sat_inc(acc7_q, n7);
         acc8_d = sat_inc(acc8_q, n8);
         idx_d  = idx_q + IDX_W'(1);
`ifdef DECODER_TTFS_EN
         if (n7 && (trk7_q == IDX_NONE)) trk7_d = idx_q;
         if (n8 && (trk8_q == IDX_NONE)) trk8_d = idx_q;
`endif
         // Results include the sample taken on this final edge.
         if (idx_q == IDX_LAST) begin
            count7_d = acc7_d;
            count8_d = acc8_d;
`ifdef DECODER_TTFS_EN
            first7_d = trk7_d;
            first8_d = trk8_d;
            winner_d = pick_winner(acc7_d, acc8_d, trk7_d, trk8_d);
`else
            winner_d = pick_winner(acc7_d, acc8_d);
`endif
         end
      end else if (start) begin
         acc7_d = '0;
         acc8_d = '0;
         idx_d  = '0;
`ifdef DECODER_TTFS_EN
         trk7_d = IDX_NONE;
         trk8_d = IDX_NONE;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc7_q   <= '0;
         acc8_q   <= '0;
         idx_q    <= '0;
         count7_q <= '0;
         count8_q <= '0;
         winner_q <= W_NONE;
`ifdef DECODER_TTFS_EN
         trk7_q   <= '0;
         trk8_q   <= '0;
         first7_q <= '0;
         first8_q <= '0;
`endif
      end else begin
         acc7_q   <= acc7_d;
         acc8_q   <= acc8_d;
         idx_q    <= idx_d;
         count7_q <= count7_d;
         count8_q <= count8_d;
         winner_q <= winner_d;
`ifdef DECODER_TTFS_EN
         trk7_q   <= trk7_d;
         trk8_q   <= trk8_d;
         first7_q <= first7_d;
         first8_q <= first8_d;
`endif
      end
   end

   assign count7 = count7_q;
   assign count8 = count8_q;
   assign winner = winner_q;
`ifdef DECODER_TTFS_EN
   assign first7 = first7_q;
   assign first8 = first8_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: a 6-bit and a 5-bit counter instance share stimulus and are
// compared window by window against a popcount/first-index reference model.
module tb_spike_rate_decoder;

   localparam int WINDOW = 40;
   localparam int IDX_W  = $clog2(WINDOW + 1);
`ifdef DECODER_TTFS_EN
   localparam bit TTFS = 1'b1;
`else
   localparam bit TTFS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic n7 = 1'b0;
   logic n8 = 1'b0;

   logic       busy6, valid6, busy5, valid5;
   logic [5:0] c7_6, c8_6;
   logic [4:0] c7_5, c8_5;
   logic [1:0] w6, w5;
`ifdef DECODER_TTFS_EN
   logic [IDX_W-1:0] f7_6, f8_6, f7_5, f8_5;
`endif

   int checks = 0;
   int errors = 0;

   int hold_c7_6 = 0, hold_c8_6 = 0, hold_w6 = 0;
   int hold_c7_5 = 0, hold_w5 = 0;

   always #5 clk = ~clk;

   spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(6)) dut6 (
      .clk(clk), .rst(rst), .start(start), .n7(n7), .n8(n8),
      .busy(busy6), .valid(valid6), .count7(c7_6), .count8(c8_6), .winner(w6)
`ifdef DECODER_TTFS_EN
      , .first7(f7_6), .first8(f8_6)
`endif
   );

   spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(5)) dut5 (
      .clk(clk), .rst(rst), .start(start), .n7(n7), .n8(n8),
      .busy(busy5), .valid(valid5), .count7(c7_5), .count8(c8_5), .winner(w5)
`ifdef DECODER_TTFS_EN
      , .first7(f7_5), .first8(f8_5)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int popc(input logic [WINDOW-1:0] p);
      int n = 0;
      for (int i = 0; i < WINDOW; i++) n += int'(p[i]);
      return n;
   endfunction

   function automatic int first_of(input logic [WINDOW-1:0] p);
      for (int i = 0; i < WINDOW; i++) if (p[i]) return i;
      return (1 << IDX_W) - 1;
   endfunction

   function automatic int sat(input int n, input int w);
      return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
   endfunction

   function automatic int ref_winner(input int c7, input int c8, input int f7, input int f8);
      if (c7 == 0 && c8 == 0) return 0;
      if (c7 > c8) return 1;
      if (c8 > c7) return 2;
      if (TTFS && f7 < f8) return 1;
      if (TTFS && f8 < f7) return 2;
      return 3;
   endfunction

   function automatic logic [WINDOW-1:0] mk(input int lo, input int n);
      logic [WINDOW-1:0] p = '0;
      for (int i = lo; i < lo + n && i < WINDOW; i++) p[i] = 1'b1;
      return p;
   endfunction

   function automatic logic [WINDOW-1:0] rnd_pat(input int pct);
      logic [WINDOW-1:0] p = '0;
      for (int i = 0; i < WINDOW; i++) p[i] = ($urandom_range(0, 99) < pct);
      return p;
   endfunction

   // Called right after the edge that samples start=1 (DUT now counting).
   // smode: 0 start low, 1 start held high, 2 random start during counting.
   task automatic count_phase(input logic [WINDOW-1:0] p7, input logic [WINDOW-1:0] p8,
                              input int smode, input logic next_start, input string tag);
      int e7_6, e8_6, e7_5, e8_5, f7, f8, ew6, ew5;
      for (int i = 0; i < WINDOW; i++) begin
         n7 = p7[i];
         n8 = p8[i];
         start = (smode == 1) ? 1'b1 : (smode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         chk({tag, ".cnt_busy"}, busy6, 1);
         chk({tag, ".cnt_valid"}, valid6, 0);
         if (i == 0 || i == WINDOW - 1) begin
            chk({tag, ".hold_c7"}, c7_6, hold_c7_6);
            chk({tag, ".hold_c8"}, c8_6, hold_c8_6);
            chk({tag, ".hold_w"}, w6, hold_w6);
            chk({tag, ".hold_c7_5"}, c7_5, hold_c7_5);
         end
         tick();
      end
      n7 = 1'b0;
      n8 = 1'b0;
      e7_6 = sat(popc(p7), 6);
      e8_6 = sat(popc(p8), 6);
      e7_5 = sat(popc(p7), 5);
      e8_5 = sat(popc(p8), 5);
      f7 = first_of(p7);
      f8 = first_of(p8);
      ew6 = ref_winner(e7_6, e8_6, f7, f8);
      ew5 = ref_winner(e7_5, e8_5, f7, f8);
      chk({tag, ".valid"}, valid6, 1);
      chk({tag, ".valid5"}, valid5, 1);
      chk({tag, ".busy"}, busy6, 1);
      chk({tag, ".count7"}, c7_6, e7_6);
      chk({tag, ".count8"}, c8_6, e8_6);
      chk({tag, ".winner"}, w6, ew6);
      chk({tag, ".count7_w5"}, c7_5, e7_5);
      chk({tag, ".count8_w5"}, c8_5, e8_5);
      chk({tag, ".winner_w5"}, w5, ew5);
`ifdef DECODER_TTFS_EN
      chk({tag, ".first7"}, f7_6, f7);
      chk({tag, ".first8"}, f8_6, f8);
      chk({tag, ".first7_w5"}, f7_5, f7);
      chk({tag, ".first8_w5"}, f8_5, f8);
`endif
      hold_c7_6 = e7_6;
      hold_c8_6 = e8_6;
      hold_w6   = ew6;
      hold_c7_5 = e7_5;
      hold_w5   = ew5;
      start = next_start;
      tick();
      chk({tag, ".post_valid"}, valid6, 0);
      chk({tag, ".post_busy"}, busy6, next_start);
      chk({tag, ".post_busy5"}, busy5, next_start);
   endtask

   task automatic begin_window();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [WINDOW-1:0] pa, pb;

      // reset state
      tick();
      chk("rst.busy", busy6, 0);
      chk("rst.valid", valid6, 0);
      chk("rst.count7", c7_6, 0);
      chk("rst.count8", c8_6, 0);
      chk("rst.winner", w6, 0);
`ifdef DECODER_TTFS_EN
      chk("rst.first7", f7_6, 0);
      chk("rst.first8", f8_6, 0);
`endif
      rst = 1'b0;

      // idle with spike activity: nothing starts
      for (int i = 0; i < 5; i++) begin
         n7 = 1'($urandom_range(0, 1));
         n8 = 1'($urandom_range(0, 1));
         tick();
         chk("idle.busy", busy6, 0);
         chk("idle.valid", valid6, 0);
      end

      // rate win
      begin_window();
      count_phase(mk(3, 10), mk(20, 5), 0, 1'b0, "rate");

      // silence
      begin_window();
      count_phase('0, '0, 0, 1'b0, "silence");

      // saturation: 40 spikes -> 40 (6 bit) and 31 (5 bit)
      pa = '1;
      begin_window();
      count_phase(pa, '0, 0, 1'b0, "sat");

      // both lines saturate in the 5-bit instance, n8 fires first
      begin_window();
      count_phase(mk(4, 36), mk(1, 39), 0, 1'b0, "satboth");

      // tie: 8 spikes each, n8 first at 2, n7 first at 5
      begin_window();
      count_phase(mk(5, 8), mk(2, 8), 0, 1'b0, "tie");

      // reset mid-window after 10 n7 spikes
      begin_window();
      n7 = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      #2 rst = 1'b1;
      #1;
      chk("abort.busy", busy6, 0);
      chk("abort.valid", valid6, 0);
      chk("abort.count7", c7_6, 0);
      chk("abort.winner", w6, 0);
      chk("abort.count7_w5", c7_5, 0);
`ifdef DECODER_TTFS_EN
      chk("abort.first8", f8_6, 0);
`endif
      hold_c7_6 = 0; hold_c8_6 = 0; hold_w6 = 0; hold_c7_5 = 0; hold_w5 = 0;
      n7 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < WINDOW + 5; i++) begin
         tick();
         chk("abort.no_valid", valid6, 0);
         chk("abort.idle", busy6, 0);
      end

      // back-to-back with start held high
      start = 1'b1;
      tick();
      count_phase(rnd_pat(30), rnd_pat(30), 1, 1'b1, "b2b0");
      count_phase(rnd_pat(60), rnd_pat(20), 1, 1'b1, "b2b1");
      count_phase(rnd_pat(10), rnd_pat(50), 1, 1'b0, "b2b2");

      // randomized windows with random start noise during counting
      for (int w = 0; w < 8; w++) begin
         pa = rnd_pat($urandom_range(0, 100));
         pb = ($urandom_range(0, 3) == 0) ? pa : rnd_pat($urandom_range(0, 100));
         begin_window();
         count_phase(pa, pb, 2, 1'($urandom_range(0, 1)), "rand");
         if (busy6) begin
            pa = rnd_pat(50);
            count_phase(pa, rnd_pat(50), 2, 1'b0, "rand_chain");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
